// File: rtl/fft_r2_stage_seq.sv
// Time-multiplexed single stage of an N-point radix-2 DIT FFT: load a frame, run N/2
// butterflies one per clock, stream the frame out. Define FFT_R2_STAGE_SCALE_EN to halve results.
module fft_r2_stage_seq #(
  parameter int unsigned DW    = 16,
  parameter int unsigned N     = 32,
  parameter int unsigned STAGE = 1,
  parameter int unsigned FRAC  = 14
) (
  input  logic                   clk_MAC,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_re,
  input  logic [DW-1:0]          in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_re,
  output logic [DW-1:0]          out_im,
  output logic [$clog2(N)-2:0]   tw_idx,
  input  logic [DW-1:0]          tw_re,
  input  logic [DW-1:0]          tw_im,
  output logic                   busy,
  output logic                   ovf
);

  localparam int unsigned LogN = $clog2(N);
  localparam int unsigned Span = 1 << STAGE;
  localparam int unsigned ExtW = DW + 2;
  localparam int unsigned PW   = 2 * DW + 1;

  localparam logic signed [DW-1:0] MaxDw = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MinDw = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

  state_e          state_q, state_d;
  logic [LogN-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            load_we, bfly_we;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];

  // Butterfly b sits in the low LogN-1 bits of the shared counter during compute.
  logic [LogN-1:0] bfly, top, bot;
  logic [LogN-2:0] tw_k;

  assign bfly = {1'b0, cnt_q[LogN-2:0]};
  assign top  = ((bfly >> STAGE) << (STAGE + 1)) | (bfly & LogN'(Span - 1));
  assign bot  = top | LogN'(Span);
  assign tw_k = (LogN-1)'((bfly & LogN'(Span - 1)) << (LogN - 1 - STAGE));

  logic signed [DW-1:0]   a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]   s_re, s_im;
  logic signed [ExtW-1:0] t_re, t_im;
  logic signed [ExtW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic [DW:0]            r_top_re, r_top_im, r_bot_re, r_bot_im;
  logic                   sat_any;

  assign a_re = mem_re[top];
  assign a_im = mem_im[top];
  assign b_re = mem_re[bot];
  assign b_im = mem_im[bot];
  assign w_re = tw_re;
  assign w_im = tw_im;

  assign p_rr = w_re * b_re;
  assign p_ii = w_im * b_im;
  assign p_ri = w_re * b_im;
  assign p_ir = w_im * b_re;

  assign s_re = PW'(p_rr) - PW'(p_ii);
  assign s_im = PW'(p_ri) + PW'(p_ir);

  // Truncating shift back to the twiddle's integer scale.
  assign t_re = ExtW'(s_re >>> FRAC);
  assign t_im = ExtW'(s_im >>> FRAC);

  assign sum_re = ExtW'(a_re) + t_re;
  assign sum_im = ExtW'(a_im) + t_im;
  assign dif_re = ExtW'(a_re) - t_re;
  assign dif_im = ExtW'(a_im) - t_im;

  // Returns {saturated, value}.
  function automatic logic [DW:0] reduce(input logic signed [ExtW-1:0] v);
    logic signed [ExtW-1:0] r;
`ifdef FFT_R2_STAGE_SCALE_EN
    r = v >>> 1;
`else
    r = v;
`endif
    if (r > ExtW'(MaxDw)) begin
      return {1'b1, MaxDw};
    end else if (r < ExtW'(MinDw)) begin
      return {1'b1, MinDw};
    end
    return {1'b0, DW'(r)};
  endfunction

  assign r_top_re = reduce(sum_re);
  assign r_top_im = reduce(sum_im);
  assign r_bot_re = reduce(dif_re);
  assign r_bot_im = reduce(dif_im);
  assign sat_any  = r_top_re[DW] | r_top_im[DW] | r_bot_re[DW] | r_bot_im[DW];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    tw_idx    = '0;
    load_we   = 1'b0;
    bfly_we   = 1'b0;
    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LogN'(N - 1)) begin
            state_d = StCompute;
            cnt_d   = '0;
          end
        end
      end
      StCompute: begin
        busy    = 1'b1;
        bfly_we = 1'b1;
        tw_idx  = tw_k;
        cnt_d   = cnt_q + 1'b1;
        if (sat_any) ovf_d = 1'b1;
        if (cnt_q == LogN'(N / 2 - 1)) begin
          state_d = StUnload;
          cnt_d   = '0;
        end
      end
      StUnload: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LogN'(N - 1)) begin
            state_d = StLoad;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = StLoad;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_MAC) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Frame buffer is deliberately left out of reset.
  always_ff @(posedge clk_MAC) begin
    if (!rst && load_we) begin
      mem_re[cnt_q] <= in_re;
      mem_im[cnt_q] <= in_im;
    end else if (!rst && bfly_we) begin
      mem_re[top] <= r_top_re[DW-1:0];
      mem_im[top] <= r_top_im[DW-1:0];
      mem_re[bot] <= r_bot_re[DW-1:0];
      mem_im[bot] <= r_bot_im[DW-1:0];
    end
  end

  assign out_re = mem_re[cnt_q];
  assign out_im = mem_im[cnt_q];
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_fft_r2_stage_seq.sv
// Bench for fft_r2_stage_seq: STAGE=1 and STAGE=0 instances share one input stream and are
// checked against an array-level DIT stage model using a true twiddle table.
module tb_fft_r2_stage_seq;

  localparam int N    = 32;
  localparam int DW   = 16;
  localparam int FRAC = 14;

  logic clk, rst, in_valid, out_ready;
  logic [DW-1:0] in_re, in_im;
  logic in_ready1, in_ready0, out_valid1, out_valid0, busy1, busy0, ovf1, ovf0;
  logic signed [DW-1:0] out_re1, out_im1, out_re0, out_im0;
  logic [$clog2(N)-2:0] tw_idx1, tw_idx0;
  logic [DW-1:0] tw_re1, tw_im1, tw_re0, tw_im0;

  int rom_re[N/2];
  int rom_im[N/2];
  int x_re[N];
  int x_im[N];
  int exp_re[2][N];
  int exp_im[2][N];
  bit exp_ovf[2];
  bit model_ovf;
  int n_checks = 0;
  int n_bad = 0;

  assign tw_re1 = DW'(rom_re[tw_idx1]);
  assign tw_im1 = DW'(rom_im[tw_idx1]);
  assign tw_re0 = DW'(rom_re[tw_idx0]);
  assign tw_im0 = DW'(rom_im[tw_idx0]);

  fft_r2_stage_seq #(.DW(DW), .N(N), .STAGE(1), .FRAC(FRAC)) u_dut1 (
    .clk_MAC(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid1), .out_ready(out_ready),
    .out_re(out_re1), .out_im(out_im1), .tw_idx(tw_idx1), .tw_re(tw_re1), .tw_im(tw_im1),
    .busy(busy1), .ovf(ovf1)
  );

  fft_r2_stage_seq #(.DW(DW), .N(N), .STAGE(0), .FRAC(FRAC)) u_dut0 (
    .clk_MAC(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid0), .out_ready(out_ready),
    .out_re(out_re0), .out_im(out_im0), .tw_idx(tw_idx0), .tw_re(tw_re0), .tw_im(tw_im0),
    .busy(busy0), .ovf(ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap18(input longint v);
    return (v <<< 46) >>> 46;
  endfunction

  function automatic int reduce(input longint v);
    longint r;
`ifdef FFT_R2_STAGE_SCALE_EN
    r = v >>> 1;
`else
    r = v;
`endif
    if (r > 32767) begin
      model_ovf = 1'b1;
      return 32767;
    end
    if (r < -32768) begin
      model_ovf = 1'b1;
      return -32768;
    end
    return int'(r);
  endfunction

  function automatic int tw_exp(input int s, input int b);
    return (b % (1 << s)) * (N / (2 << s));
  endfunction

  // One DIT stage over the whole frame: pair each lower index with its partner SPAN above.
  task automatic model(input int s);
    int span, bot, k;
    longint t_re, t_im;
    span = 1 << s;
    model_ovf = 1'b0;
    for (int top = 0; top < N; top++) begin
      if ((top / span) % 2 == 0) begin
        bot  = top + span;
        k    = (top % span) * (N / (2 * span));
        t_re = wrap18((longint'(rom_re[k]) * x_re[bot] - longint'(rom_im[k]) * x_im[bot])
                      >>> FRAC);
        t_im = wrap18((longint'(rom_re[k]) * x_im[bot] + longint'(rom_im[k]) * x_re[bot])
                      >>> FRAC);
        exp_re[s][top] = reduce(longint'(x_re[top]) + t_re);
        exp_im[s][top] = reduce(longint'(x_im[top]) + t_im);
        exp_re[s][bot] = reduce(longint'(x_re[top]) - t_re);
        exp_im[s][bot] = reduce(longint'(x_im[top]) - t_im);
      end
    end
    exp_ovf[s] = model_ovf;
  endtask

  task automatic clear_x();
    for (int k = 0; k < N; k++) begin
      x_re[k] = 0;
      x_im[k] = 0;
    end
  endtask

  task automatic fill_random(input int range);
    for (int k = 0; k < N; k++) begin
      x_re[k] = int'($urandom_range(2 * range)) - range;
      x_im[k] = int'($urandom_range(2 * range)) - range;
    end
  endtask

  task automatic drive_frame(input int gap, input bit keep);
    int k, n;
    bit take;
    k = 0;
    n = 0;
    while (k < N && n < 8 * N) begin
      check("load_in_ready1", in_ready1, 1);
      check("load_in_ready0", in_ready0, 1);
      check("load_busy", busy1, 0);
      check("load_ovf", ovf1, 0);
      in_valid = ($urandom_range(99) >= gap);
      in_re    = DW'(x_re[k]);
      in_im    = DW'(x_im[k]);
      take     = in_valid;
      @(posedge clk);
      #1;
      n++;
      if (take) k++;
    end
    check("load_count", k, N);
    if (keep) begin
      in_re = 16'h5a5a;
      in_im = 16'ha5a5;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, else random.
  task automatic receive_frame(input int mode, output int cycles);
    int idx, cyc, pc;
    bit take;
    idx = 0;
    cyc = 0;
    pc  = 0;
    while (idx < N && cyc < 8 * N) begin
      check("busy1", busy1, 1);
      check("busy0", busy0, 1);
      check("in_ready_busy", in_ready1, 0);
      check("out_valid1", out_valid1, int'(cyc >= N / 2));
      check("out_valid0", out_valid0, int'(cyc >= N / 2));
      if (cyc < N / 2) begin
        check("tw_idx1", tw_idx1, tw_exp(1, cyc));
        check("tw_idx0", tw_idx0, tw_exp(0, cyc));
        out_ready = (mode == 0);
      end else begin
        check("ovf1", ovf1, exp_ovf[1]);
        check("ovf0", ovf0, exp_ovf[0]);
        check("out_re1", int'(out_re1), exp_re[1][idx]);
        check("out_im1", int'(out_im1), exp_im[1][idx]);
        check("out_re0", int'(out_re0), exp_re[0][idx]);
        check("out_im0", int'(out_im0), exp_im[0][idx]);
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (pc % 4 == 0) || (pc % 4 == 3);
          default: out_ready = $urandom_range(1) == 1;
        endcase
        pc++;
      end
      take = out_valid1 && out_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (take) idx++;
    end
    check("unload_count", idx, N);
    check("next_in_ready", in_ready1, 1);
    check("next_out_valid", out_valid1, 0);
    check("next_busy", busy1, 0);
    check("next_ovf1", ovf1, 0);
    check("next_ovf0", ovf0, 0);
    cycles = cyc;
  endtask

  task automatic run_frame(input int gap, input int mode);
    int cyc;
    model(0);
    model(1);
    drive_frame(gap, 1'b0);
    receive_frame(mode, cyc);
  endtask

  initial begin
    int cyc;
    real ang;
    for (int k = 0; k < N / 2; k++) begin
      ang = 2.0 * 3.14159265358979 * k / N;
      rom_re[k] = int'($cos(ang) * 16384.0);
      rom_im[k] = int'(-$sin(ang) * 16384.0);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_re = '0;
    in_im = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready1, 1);
    check("rst_out_valid", out_valid1, 0);
    check("rst_busy", busy1, 0);
    check("rst_ovf", ovf1, 0);
    check("rst_tw_idx", tw_idx1, 0);
    check("rst_busy0", busy0, 0);

    // Impulse, -j twiddle at b=1, saturation, then ramp under backpressure.
    clear_x();
    x_re[0] = 1000;
    run_frame(0, 0);
    clear_x();
    x_re[3] = 4096;
    run_frame(0, 0);
    clear_x();
    x_re[0] = 30000;
    x_re[2] = 30000;
    run_frame(0, 0);
    for (int k = 0; k < N; k++) begin
      x_re[k] = k;
      x_im[k] = -k;
    end
    run_frame(0, 1);

    // Reset on the 5th compute cycle of a saturating frame.
    clear_x();
    x_re[0] = 30000;
    x_re[2] = 30000;
    drive_frame(0, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready1, 1);
    check("mid_rst_out_valid", out_valid1, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_ovf", ovf1, 0);
    fill_random(8000);
    run_frame(20, 2);

    // Back-to-back frames with in_valid and out_ready held high.
    out_ready = 1'b1;
    fill_random(32768);
    model(0);
    model(1);
    drive_frame(0, 1'b1);
    receive_frame(0, cyc);
    check("thru_cycles", cyc, N / 2 + N);
    fill_random(8000);
    model(0);
    model(1);
    drive_frame(0, 1'b0);
    receive_frame(0, cyc);
    check("thru_cycles2", cyc, N / 2 + N);

    for (int f = 0; f < 4; f++) begin
      fill_random((f % 2 == 0) ? 32768 : 12000);
      run_frame(30, 2);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
